// File: rtl/core_param_pkg.sv
// core_param_pkg: opcodes, FSM states and instruction field helpers for core_param.
package core_param_pkg;
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDI   = 4'h1;
    localparam logic [3:0] OP_MOV   = 4'h2;
    localparam logic [3:0] OP_MVA   = 4'h3;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_SUB   = 4'h5;
    localparam logic [3:0] OP_MUL   = 4'h6;
    localparam logic [3:0] OP_INC   = 4'h7;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_JZ    = 4'hA;
    localparam logic [3:0] OP_JNZ   = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [3:0] OP_CID   = 4'hD;
    localparam logic [3:0] OP_DEC   = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    function automatic int op_lsb(input int rb, input int dw);
        return rb + dw;
    endfunction

    function automatic int reg_lsb(input int dw);
        return dw;
    endfunction
endpackage

// File: rtl/core_param_regfile.sv
// core_param_regfile: NREG x DATA_W register file, one write port, one combinational read port.
module core_param_regfile #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8,
    parameter int RB     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [RB-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RB-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];
endmodule

// File: rtl/core_param.sv
// core_param: accumulator core with register file, handshaked fetch and data access, per-core ID.
module core_param
    import core_param_pkg::*;
#(
    parameter int                DATA_W  = 8,
    parameter int                IADDR_W = 8,
    parameter int                DADDR_W = 8,
    parameter int                NREG    = 8,
    parameter logic [DATA_W-1:0] CIDval  = '0,
    parameter int                RB      = $clog2(NREG),
    parameter int                IW      = 4 + RB + DATA_W
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [IW-1:0]      Idin,
    input  logic               iacq,
    input  logic [DATA_W-1:0]  Ddin,
    input  logic               acq,
    output logic [IADDR_W-1:0] IAddress,
    output logic               ireq,
    output logic [DADDR_W-1:0] DAddress,
    output logic [DATA_W-1:0]  Ddout,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic [DATA_W-1:0]  ACo,
    output logic [IW-1:0]      INS,
    output logic               halted
);
    localparam int OP_LSB  = op_lsb(RB, DATA_W);
    localparam int REG_LSB = reg_lsb(DATA_W);

    state_t             state;
    logic [IADDR_W-1:0] pc;
    logic [DATA_W-1:0]  ac;
    logic [IW-1:0]      ir;
    logic [3:0]         op;
    logic [RB-1:0]      rsel;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  r;
    logic [DATA_W-1:0]  mul_lo;
    logic [DATA_W-1:0]  ac_next;
    logic [DATA_W-1:0]  rf_wdata;
    logic               ac_we;
    logic               rf_we;
    logic               take;
    logic               in_mem;

    assign op     = ir[OP_LSB +: 4];
    assign rsel   = ir[REG_LSB +: RB];
    assign imm    = ir[DATA_W-1:0];
    assign mul_lo = ac * r;

    core_param_regfile #(.DATA_W(DATA_W), .NREG(NREG), .RB(RB)) u_rf (
        .clk   (CLK),
        .rst_n (RST_N),
        .we    (rf_we),
        .waddr (rsel),
        .wdata (rf_wdata),
        .raddr (rsel),
        .rdata (r)
    );

    always_comb begin
        ac_we    = state == S_EXEC && (op == OP_LDI || op == OP_MVA || op == OP_ADD ||
                   op == OP_SUB || op == OP_MUL || op == OP_CID);
        ac_next  = op == OP_LDI ? imm :
                   op == OP_MVA ? r :
                   op == OP_ADD ? ac + r :
                   op == OP_SUB ? ac - r :
                   op == OP_MUL ? mul_lo : CIDval;
        rf_we    = state == S_EXEC && (op == OP_MOV || op == OP_INC || op == OP_DEC);
        rf_wdata = op == OP_MOV ? ac : op == OP_INC ? r + DATA_W'(1) : r - DATA_W'(1);
        take     = op == OP_JMP || (op == OP_JZ && r == '0) || (op == OP_JNZ && r != '0);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_FETCH;
            pc    <= '0;
            ac    <= '0;
            ir    <= '0;
        end else begin
            case (state)
                S_FETCH: if (iacq) begin
                    ir    <= Idin;
                    pc    <= pc + IADDR_W'(1);
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (ac_we) ac <= ac_next;
                    if (state == S_EXEC && take) pc <= imm[IADDR_W-1:0];
                    state <= (op == OP_LOAD || op == OP_STORE) ? S_MEM :
                             op == OP_HALT ? S_HALT : S_FETCH;
                end
                S_MEM: if (acq) begin
                    if (op == OP_LOAD) ac <= Ddin;
                    state <= S_FETCH;
                end
                default: state <= S_HALT;
            endcase
        end
    end

    // Requests decode straight from state; the fetch request is also gated by reset itself.
    assign in_mem   = state == S_MEM;
    assign ireq     = RST_N && state == S_FETCH;
    assign mem_rd   = in_mem && op == OP_LOAD;
    assign mem_wr   = in_mem && op == OP_STORE;
    assign DAddress = in_mem ? r[DADDR_W-1:0] : '0;
    assign Ddout    = ac;
    assign IAddress = pc;
    assign ACo      = ac;
    assign INS      = ir;
    assign halted   = state == S_HALT;
endmodule

// File: tb/tb_core_param.sv
// tb_core_param: directed programs against memory models, scoreboard of expected stores and results.
module tb_core_param;
    import core_param_pkg::*;

    logic        CLK = 0;
    logic        RST_N;
    logic [14:0] Idin;
    logic        iacq, acq;
    logic [7:0]  Ddin;
    logic [7:0]  IAddress, DAddress, Ddout, ACo;
    logic        ireq, mem_rd, mem_wr, halted;
    logic [14:0] INS;

    logic [21:0] w_idin;
    logic [7:0]  w_iaddr, w_daddr;
    logic [15:0] w_ddout, w_aco;
    logic        w_ireq, w_rd, w_wr, w_halted;
    logic [21:0] w_ins;
    logic [21:0] imem16 [256];

    always #5 CLK = ~CLK;

    core_param #(.DATA_W(8), .IADDR_W(8), .DADDR_W(8), .NREG(8), .CIDval(8'd3)) dut (
        .CLK(CLK), .RST_N(RST_N), .Idin(Idin), .iacq(iacq), .Ddin(Ddin), .acq(acq),
        .IAddress(IAddress), .ireq(ireq), .DAddress(DAddress), .Ddout(Ddout),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .ACo(ACo), .INS(INS), .halted(halted)
    );

    core_param #(.DATA_W(16), .IADDR_W(8), .DADDR_W(8), .NREG(4), .CIDval(16'd9)) dut16 (
        .CLK(CLK), .RST_N(RST_N), .Idin(w_idin), .iacq(1'b1), .Ddin(16'h0), .acq(1'b0),
        .IAddress(w_iaddr), .ireq(w_ireq), .DAddress(w_daddr), .Ddout(w_ddout),
        .mem_rd(w_rd), .mem_wr(w_wr), .ACo(w_aco), .INS(w_ins), .halted(w_halted)
    );

    assign w_idin = imem16[w_iaddr];

    logic [14:0] imem [256];
    logic [7:0]  dmem [256];
    logic [15:0] st_q [$];
    logic [7:0]  ac_q [$];
    int n_cmp = 0, n_err = 0;
    int iwait, dwait, icnt, dcnt, fetches, f2, wr_cycles, rd_cycles;
    logic stray_acq;

    function automatic logic [14:0] enc(input logic [3:0] o, input logic [2:0] rg, input logic [7:0] im);
        return {o, rg, im};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) imem[i] = enc(OP_NOP, 3'd0, 8'h00);
    endtask

    task automatic rst();
        @(negedge CLK);
        RST_N = 0; iacq = 0; acq = 0; stray_acq = 0;
        icnt = 0; dcnt = 0; fetches = 0; f2 = 0; wr_cycles = 0; rd_cycles = 0;
        @(negedge CLK);
        RST_N = 1;
    endtask

    // One cycle of memory-model response, decided from the outputs at the falling edge.
    task automatic step();
        logic [15:0] e;
        @(negedge CLK);
        iacq = 0;
        acq  = stray_acq;
        if (ireq) begin
            if (icnt >= iwait) begin
                iacq = 1; Idin = imem[IAddress]; icnt = 0; fetches++;
                if (IAddress == 8'd2) f2++;
            end else icnt++;
        end
        if (mem_wr || mem_rd) begin
            if (mem_wr) wr_cycles++; else rd_cycles++;
            if (dcnt >= dwait) begin
                acq = 1; dcnt = 0;
                if (mem_wr) begin
                    e = (st_q.size() != 0) ? st_q.pop_front() : 16'hxxxx;
                    chk("store_txn", {DAddress, Ddout}, e);
                    dmem[DAddress] = Ddout;
                end else Ddin = dmem[DAddress];
            end else dcnt++;
        end
    endtask

    task automatic run_halt(input string tag, input int bound);
        logic [7:0] e;
        for (int i = 0; i < bound && !halted; i++) step();
        iacq = 0; acq = 0; stray_acq = 0;
        chk({tag, "_halted"}, halted, 1'b1);
        e = (ac_q.size() != 0) ? ac_q.pop_front() : 8'hxx;
        chk({tag, "_ac"}, ACo, e);
        chk({tag, "_idle_bus"}, {ireq, mem_rd, mem_wr, DAddress}, 11'h0);
    endtask

    initial begin
        RST_N = 0; iacq = 0; acq = 0; Idin = '0; Ddin = '0; stray_acq = 0;
        iwait = 0; dwait = 0;
        for (int i = 0; i < 256; i++) begin dmem[i] = 8'h00; imem16[i] = '0; end
        imem16[0] = {OP_LDI, 2'd0, 16'h00FF};
        imem16[1] = {OP_MOV, 2'd1, 16'h0000};
        imem16[2] = {OP_INC, 2'd1, 16'h0000};
        imem16[3] = {OP_MVA, 2'd1, 16'h0000};
        imem16[4] = {OP_HALT, 2'd0, 16'h0000};
        clear_prog();
        imem[0] = enc(OP_LDI, 3'd0, 8'h55);
        rst();

        // reset while a fetch is stalled
        step(); step();
        iwait = 100;
        step();
        chk("stall_ireq", ireq, 1'b1);
        chk("stall_pc", IAddress, 8'd1);
        chk("stall_ac", ACo, 8'h55);
        #1 RST_N = 0;
        #1;
        chk("rst_ireq", ireq, 1'b0);
        chk("rst_pc", IAddress, 8'd0);
        chk("rst_ac", ACo, 8'd0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_ins", INS, 15'd0);
        @(negedge CLK);
        RST_N = 1;
        #1 chk("release_ireq", ireq, 1'b1);
        iwait = 0; icnt = 0;

        // multiply program
        clear_prog();
        imem[0] = enc(OP_LDI, 3'd0, 8'd5);
        imem[1] = enc(OP_MOV, 3'd1, 8'd0);
        imem[2] = enc(OP_LDI, 3'd0, 8'd3);
        imem[3] = enc(OP_MUL, 3'd1, 8'd0);
        imem[4] = enc(OP_HALT, 3'd0, 8'd0);
        ac_q.push_back(8'h0F);
        rst();
        run_halt("mul", 40);
        chk("mul_fetches", fetches, 5);
        chk("wide_halted", w_halted, 1'b1);
        chk("wide_ac", w_aco, 16'h0100);

        // store then load with data wait states
        clear_prog();
        imem[0] = enc(OP_LDI, 3'd0, 8'h20);
        imem[1] = enc(OP_MOV, 3'd2, 8'd0);
        imem[2] = enc(OP_LDI, 3'd0, 8'hAA);
        imem[3] = enc(OP_STORE, 3'd2, 8'd0);
        imem[4] = enc(OP_LDI, 3'd0, 8'h11);
        imem[5] = enc(OP_LOAD, 3'd2, 8'd0);
        imem[6] = enc(OP_HALT, 3'd0, 8'd0);
        st_q.push_back(16'h20AA);
        ac_q.push_back(8'hAA);
        rst();
        dwait = 3; dcnt = 0;
        run_halt("mem", 80);
        chk("wr_cycles", wr_cycles, 4);
        chk("rd_cycles", rd_cycles, 4);
        chk("store_q_empty", st_q.size(), 0);
        dwait = 0;

        // countdown loop
        clear_prog();
        imem[0] = enc(OP_LDI, 3'd0, 8'd3);
        imem[1] = enc(OP_MOV, 3'd0, 8'd0);
        imem[2] = enc(OP_DEC, 3'd0, 8'd0);
        imem[3] = enc(OP_JNZ, 3'd0, 8'd2);
        imem[4] = enc(OP_HALT, 3'd0, 8'd0);
        ac_q.push_back(8'd3);
        rst();
        run_halt("loop", 80);
        chk("loop_dec_count", f2, 3);
        chk("loop_pc", IAddress, 8'd5);

        // register increment wraps
        clear_prog();
        imem[0] = enc(OP_LDI, 3'd0, 8'hFF);
        imem[1] = enc(OP_MOV, 3'd1, 8'd0);
        imem[2] = enc(OP_INC, 3'd1, 8'd0);
        imem[3] = enc(OP_MVA, 3'd1, 8'd0);
        imem[4] = enc(OP_HALT, 3'd0, 8'd0);
        ac_q.push_back(8'h00);
        rst();
        run_halt("wrap", 40);

        // PC wraps from 0xFF to 0
        clear_prog();
        imem[0]   = enc(OP_JNZ, 3'd4, 8'd3);
        imem[1]   = enc(OP_INC, 3'd4, 8'd0);
        imem[2]   = enc(OP_JMP, 3'd0, 8'hFF);
        imem[3]   = enc(OP_LDI, 3'd0, 8'h77);
        imem[4]   = enc(OP_HALT, 3'd0, 8'd0);
        imem[255] = enc(OP_NOP, 3'd0, 8'd0);
        ac_q.push_back(8'h77);
        rst();
        run_halt("pcwrap", 60);
        chk("pcwrap_pc", IAddress, 8'd5);

        // core ID, taken JZ/JMP, ADD, with stray acq pulses outside MEM
        clear_prog();
        imem[0] = enc(OP_CID, 3'd0, 8'd0);
        imem[1] = enc(OP_JZ, 3'd7, 8'd4);
        imem[2] = enc(OP_LDI, 3'd0, 8'h99);
        imem[3] = enc(OP_HALT, 3'd0, 8'd0);
        imem[4] = enc(OP_JMP, 3'd0, 8'd6);
        imem[5] = enc(OP_HALT, 3'd0, 8'd0);
        imem[6] = enc(OP_MOV, 3'd3, 8'd0);
        imem[7] = enc(OP_ADD, 3'd3, 8'd0);
        imem[8] = enc(OP_HALT, 3'd0, 8'd0);
        ac_q.push_back(8'd6);
        rst();
        Ddin = 8'hEE;
        stray_acq = 1;
        run_halt("cid", 60);
        chk("stray_rd", rd_cycles + wr_cycles, 0);
        chk("cid_pc", IAddress, 8'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
